// File: rtl/spi_frame_slave.sv
// SPI mode 0 frame slave: oversampled cmd/addr/payload deframer with brightness register.
// Define SPI_SLAVE_MISO_TRISTATE_EN to release miso (1'bz) outside a frame and in reset.
module spi_frame_slave #(
    parameter int CMD_BITS         = 4,
    parameter int ADDR_BITS        = 4,
    parameter int PAYLOAD_BITS     = 8,
    parameter int BRIGHTNESS_WIDTH = 7,
    parameter logic [CMD_BITS-1:0] CMD_WRITE = 'h1
) (
    input  logic                        sysclk,
    input  logic                        rst,
    input  logic                        cs,
    input  logic                        sclk,
    input  logic                        mosi,
    output logic                        miso,
    output logic [CMD_BITS-1:0]         o_cmd,
    output logic [ADDR_BITS-1:0]        o_addr,
    output logic [PAYLOAD_BITS-1:0]     o_payload,
    output logic                        o_rx_dv,
    output logic                        o_frame_err,
    output logic [BRIGHTNESS_WIDTH-1:0] o_brightness
);

    localparam int TOTAL = CMD_BITS + ADDR_BITS + PAYLOAD_BITS;
    localparam int CNT_W = $clog2(TOTAL + 1);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        COMMIT,
        WAIT_CS
    } state_t;

    state_t state;

    logic [2:0] cs_sr;
    logic [2:0] sclk_sr;
    logic [1:0] mosi_sr;

    logic cs_sync;
    logic mosi_sync;
    logic cs_fall;
    logic cs_rise;
    logic sclk_rise;
    logic sclk_fall;

    logic [TOTAL-1:0] rx_shift;
    logic [TOTAL-1:0] tx_shift;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] fld_w;

    logic [CMD_BITS-1:0]     rx_cmd;
    logic [ADDR_BITS-1:0]    rx_addr;
    logic [PAYLOAD_BITS-1:0] rx_payload;

    // Synchronizers are left unreset so reset can see the true cs level.
    always_ff @(posedge sysclk) begin
        cs_sr   <= {cs_sr[1:0], cs};
        sclk_sr <= {sclk_sr[1:0], sclk};
        mosi_sr <= {mosi_sr[0], mosi};
    end

    assign cs_sync   = cs_sr[1];
    assign mosi_sync = mosi_sr[1];
    assign cs_fall   = !cs_sr[1] && cs_sr[2];
    assign cs_rise   = cs_sr[1] && !cs_sr[2];
    assign sclk_rise = sclk_sr[1] && !sclk_sr[2];
    assign sclk_fall = !sclk_sr[1] && sclk_sr[2];

    assign cnt_nxt = bit_cnt + 1'b1;

    assign rx_cmd     = rx_shift[TOTAL-1 -: CMD_BITS];
    assign rx_addr    = rx_shift[PAYLOAD_BITS +: ADDR_BITS];
    assign rx_payload = rx_shift[PAYLOAD_BITS-1:0];

    always_comb begin
        fld_w = CNT_W'(CMD_BITS);
        unique case (state)
            ADDR:    fld_w = CNT_W'(ADDR_BITS);
            DATA:    fld_w = CNT_W'(PAYLOAD_BITS);
            default: ;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state        <= cs_sync ? IDLE : WAIT_CS;
            rx_shift     <= '0;
            tx_shift     <= '0;
            bit_cnt      <= '0;
            o_cmd        <= '0;
            o_addr       <= '0;
            o_payload    <= '0;
            o_rx_dv      <= 1'b0;
            o_frame_err  <= 1'b0;
            o_brightness <= '0;
        end else begin
            o_rx_dv     <= 1'b0;
            o_frame_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cs_fall) begin
                        tx_shift <= {{(TOTAL-BRIGHTNESS_WIDTH){1'b0}},
                                     o_brightness};
                        bit_cnt  <= '0;
                        state    <= CMD;
                    end
                end
                CMD, ADDR, DATA: begin
                    if (cs_rise) begin
                        o_frame_err <= 1'b1;
                        state       <= IDLE;
                    end else if (sclk_rise) begin
                        rx_shift <= {rx_shift[TOTAL-2:0], mosi_sync};
                        if (cnt_nxt == fld_w) begin
                            bit_cnt <= '0;
                            unique case (state)
                                CMD:     state <= ADDR;
                                ADDR:    state <= DATA;
                                default: state <= COMMIT;
                            endcase
                        end else begin
                            bit_cnt <= cnt_nxt;
                        end
                    end else if (sclk_fall) begin
                        tx_shift <= {tx_shift[TOTAL-2:0], 1'b0};
                    end
                end
                COMMIT: begin
                    o_cmd     <= rx_cmd;
                    o_addr    <= rx_addr;
                    o_payload <= rx_payload;
                    o_rx_dv   <= 1'b1;
                    if (rx_cmd == CMD_WRITE && rx_addr == '0)
                        o_brightness <= rx_payload[BRIGHTNESS_WIDTH-1:0];
                    // A cs rise here would otherwise be lost to WAIT_CS.
                    state <= cs_rise ? IDLE : WAIT_CS;
                end
                WAIT_CS: begin
                    if (cs_rise)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    assign miso = (rst || cs_sync) ? 1'bz : tx_shift[TOTAL-1];
`else
    assign miso = (rst || cs_sync) ? 1'b0 : tx_shift[TOTAL-1];
`endif

endmodule

// File: tb/tb_spi_frame_slave.sv
// Directed bench for spi_frame_slave: framed writes, reads, aborts, overruns, reset.
module tb_spi_frame_slave;

    logic       sysclk = 1'b0;
    logic       rst;
    logic       cs;
    logic       sclk;
    logic       mosi;
    wire        miso;
    logic [3:0] o_cmd;
    logic [3:0] o_addr;
    logic [7:0] o_payload;
    logic       o_rx_dv;
    logic       o_frame_err;
    logic [6:0] o_brightness;

    int tests  = 0;
    int fails  = 0;
    int dv_cnt = 0;
    int fe_cnt = 0;

    logic       miso_idle_exp;
    logic [31:0] cap;

    spi_frame_slave dut (
        .sysclk       (sysclk),
        .rst          (rst),
        .cs           (cs),
        .sclk         (sclk),
        .mosi         (mosi),
        .miso         (miso),
        .o_cmd        (o_cmd),
        .o_addr       (o_addr),
        .o_payload    (o_payload),
        .o_rx_dv      (o_rx_dv),
        .o_frame_err  (o_frame_err),
        .o_brightness (o_brightness)
    );

    always #4 sysclk = ~sysclk;

    always @(negedge sysclk) begin
        if (o_rx_dv === 1'b1)
            dv_cnt++;
        if (o_frame_err === 1'b1)
            fe_cnt++;
    end

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    initial miso_idle_exp = 1'bz;
`else
    initial miso_idle_exp = 1'b0;
`endif

    task automatic cycles(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    // Master side: sends nbits MSB first, samples miso before each rise.
    task automatic xfer(input logic [31:0] data, input int nbits,
                        output logic [31:0] got);
        got = '0;
        cs = 1'b0;
        cycles(8);
        for (int i = 0; i < nbits; i++) begin
            mosi = data[nbits-1-i];
            cycles(4);
            got = {got[30:0], miso};
            sclk = 1'b1;
            cycles(4);
            sclk = 1'b0;
        end
        cycles(4);
        cs = 1'b1;
        cycles(10);
    endtask

    task automatic test_reset;
        rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
        cycles(6);
        tests++;
        if (miso !== miso_idle_exp) begin
            fails++;
            $display("FAIL reset_miso: got %b want %b", miso, miso_idle_exp);
        end
        rst = 1'b0;
        cycles(4);
        tests++;
        if ({o_cmd, o_addr, o_payload, o_brightness, o_rx_dv, o_frame_err} !== '0) begin
            fails++;
            $display("FAIL reset_outs: cmd %h addr %h pay %h bri %h dv %b fe %b",
                     o_cmd, o_addr, o_payload, o_brightness, o_rx_dv, o_frame_err);
        end
        tests++;
        if (miso !== miso_idle_exp) begin
            fails++;
            $display("FAIL idle_miso: got %b want %b", miso, miso_idle_exp);
        end
    endtask

    task automatic test_write;
        int d0 = dv_cnt;
        xfer(32'h1055, 16, cap);
        tests++;
        if (dv_cnt - d0 != 1) begin
            fails++;
            $display("FAIL write_dv: got %0d pulses want 1", dv_cnt - d0);
        end
        tests++;
        if (o_cmd !== 4'h1 || o_addr !== 4'h0 || o_payload !== 8'h55) begin
            fails++;
            $display("FAIL write_fields: got %h/%h/%h want 1/0/55",
                     o_cmd, o_addr, o_payload);
        end
        tests++;
        if (o_brightness !== 7'h55) begin
            fails++;
            $display("FAIL write_bri: got %h want 55", o_brightness);
        end
    endtask

    task automatic test_readback;
        int d0 = dv_cnt;
        xfer(32'h2300, 16, cap);
        tests++;
        if (cap[15:0] !== 16'h0055) begin
            fails++;
            $display("FAIL readback_miso: got %h want 0055", cap[15:0]);
        end
        tests++;
        if (dv_cnt - d0 != 1 || o_cmd !== 4'h2 || o_addr !== 4'h3) begin
            fails++;
            $display("FAIL readback_dv: dv %0d cmd %h addr %h want 1/2/3",
                     dv_cnt - d0, o_cmd, o_addr);
        end
        tests++;
        if (o_brightness !== 7'h55) begin
            fails++;
            $display("FAIL readback_bri: got %h want 55", o_brightness);
        end
    endtask

    task automatic test_bad_addr;
        int d0 = dv_cnt;
        xfer(32'h157F, 16, cap);
        tests++;
        if (dv_cnt - d0 != 1 || o_addr !== 4'h5 || o_payload !== 8'h7F) begin
            fails++;
            $display("FAIL badaddr_dv: dv %0d addr %h pay %h want 1/5/7f",
                     dv_cnt - d0, o_addr, o_payload);
        end
        tests++;
        if (o_brightness !== 7'h55) begin
            fails++;
            $display("FAIL badaddr_bri: got %h want 55", o_brightness);
        end
    endtask

    task automatic test_abort;
        int d0 = dv_cnt;
        int f0 = fe_cnt;
        xfer(32'h0000_03FF, 10, cap);
        tests++;
        if (fe_cnt - f0 != 1 || dv_cnt - d0 != 0) begin
            fails++;
            $display("FAIL abort_pulses: fe %0d dv %0d want 1/0",
                     fe_cnt - f0, dv_cnt - d0);
        end
        tests++;
        if (o_cmd !== 4'h1 || o_addr !== 4'h5 || o_payload !== 8'h7F) begin
            fails++;
            $display("FAIL abort_hold: got %h/%h/%h want 1/5/7f",
                     o_cmd, o_addr, o_payload);
        end
        d0 = dv_cnt;
        xfer(32'h102A, 16, cap);
        tests++;
        if (dv_cnt - d0 != 1 || o_brightness !== 7'h2A) begin
            fails++;
            $display("FAIL abort_recover: dv %0d bri %h want 1/2a",
                     dv_cnt - d0, o_brightness);
        end
    endtask

    task automatic test_overrun;
        int d0 = dv_cnt;
        xfer(32'h0001_033F, 20, cap);
        tests++;
        if (dv_cnt - d0 != 1) begin
            fails++;
            $display("FAIL overrun_dv: got %0d pulses want 1", dv_cnt - d0);
        end
        tests++;
        if (o_cmd !== 4'h1 || o_addr !== 4'h0 || o_payload !== 8'h33
            || o_brightness !== 7'h33) begin
            fails++;
            $display("FAIL overrun_fields: got %h/%h/%h bri %h want 1/0/33/33",
                     o_cmd, o_addr, o_payload, o_brightness);
        end
    endtask

    task automatic test_reset_midframe;
        logic [15:0] w = 16'h1066;
        int d0;
        cs = 1'b0;
        cycles(8);
        for (int i = 0; i < 6; i++) begin
            mosi = w[15-i];
            cycles(4);
            sclk = 1'b1;
            cycles(4);
            sclk = 1'b0;
        end
        rst = 1'b1;
        cycles(2);
        tests++;
        if (miso !== miso_idle_exp) begin
            fails++;
            $display("FAIL midrst_miso: got %b want %b", miso, miso_idle_exp);
        end
        rst = 1'b0;
        d0 = dv_cnt;
        cycles(1);
        tests++;
        if ({o_cmd, o_addr, o_payload, o_brightness} !== '0) begin
            fails++;
            $display("FAIL midrst_outs: got %h/%h/%h bri %h want 0",
                     o_cmd, o_addr, o_payload, o_brightness);
        end
        for (int i = 6; i < 16; i++) begin
            mosi = w[15-i];
            cycles(4);
            sclk = 1'b1;
            cycles(4);
            sclk = 1'b0;
        end
        cycles(4);
        cs = 1'b1;
        cycles(10);
        tests++;
        if (dv_cnt - d0 != 0 || o_brightness !== 7'h00) begin
            fails++;
            $display("FAIL midrst_nocommit: dv %0d bri %h want 0/0",
                     dv_cnt - d0, o_brightness);
        end
        tests++;
        if (miso !== miso_idle_exp) begin
            fails++;
            $display("FAIL midrst_idle_miso: got %b want %b", miso, miso_idle_exp);
        end
        d0 = dv_cnt;
        xfer(32'h1011, 16, cap);
        tests++;
        if (dv_cnt - d0 != 1 || o_payload !== 8'h11 || o_brightness !== 7'h11
            || cap[15:0] !== 16'h0000) begin
            fails++;
            $display("FAIL midrst_next: dv %0d pay %h bri %h miso %h want 1/11/11/0000",
                     dv_cnt - d0, o_payload, o_brightness, cap[15:0]);
        end
    endtask

    initial begin
        test_reset;
        test_write;
        test_readback;
        test_bad_addr;
        test_abort;
        test_overrun;
        test_reset_midframe;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
